// File: rtl/alu_pkg.sv
// Shared definitions for the sequential accumulator ALU: opcodes, flag bit
// positions, FSM state encoding and a helper to assemble the flag nibble.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_PASS = 4'd5;
    localparam logic [3:0] OP_ADC  = 4'd6;
    localparam logic [3:0] OP_SHL  = 4'd7;
    localparam logic [3:0] OP_SHR  = 4'd8;
    localparam logic [3:0] OP_ASR  = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;

    localparam int FLG_Z = 3;
    localparam int FLG_N = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_MUL   = 2'd2
    } state_t;

    // Place the four status bits at their architectural positions.
    function automatic logic [3:0] pack_flags(input logic z, input logic n,
                                              input logic c, input logic v);
        logic [3:0] f;
        f        = 4'b0000;
        f[FLG_Z] = z;
        f[FLG_N] = n;
        f[FLG_C] = c;
        f[FLG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/alu_adder_n.sv
// WIDTH-bit ripple-carry adder with carry in, carry out and signed overflow.
// Shared by ADD/SUB/ADC and by the multiplier partial-sum accumulate.
module alu_adder_n #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_y,
    output logic             o_cout,
    output logic             o_v
);

    // Ripple the carry LSB to MSB; overflow compares carry into and out of the MSB.
    always_comb begin : p_ripple
        logic v_c;
        logic v_c_msb;
        o_y     = '0;
        v_c     = i_cin;
        v_c_msb = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i == WIDTH - 1) begin
                v_c_msb = v_c;
            end
            o_y[i] = i_a[i] ^ i_b[i] ^ v_c;
            v_c    = (i_a[i] & i_b[i]) | ((i_a[i] ^ i_b[i]) & v_c);
        end
        o_cout = v_c;
        o_v    = v_c ^ v_c_msb;
    end

endmodule

// File: rtl/alu_seq_acc.sv
// Sequential accumulator ALU with valid/ready request handshake.
// Single-cycle arithmetic/logic ops, one-bit-per-cycle shifts and, when the
// macro ALU_MUL_EN is defined, a WIDTH-iteration shift-add multiplier.
// Without ALU_MUL_EN opcode 10 falls through to PASS and no multiplier exists.
module alu_seq_acc
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic             use_acc,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             out_valid,
    output logic             busy
);

    state_t           r_state, w_state_next;
    logic [WIDTH-1:0] r_result, w_result_next;
    logic [3:0]       r_flags, w_flags_next;
    logic [WIDTH-1:0] r_acc, w_acc_next;
    logic             r_out_valid, w_out_valid_next;
    logic [3:0]       r_op, w_op_next;
    logic [WIDTH-1:0] r_work, w_work_next;   // shift operand, or multiplier/low product
    logic [SHW-1:0]   r_cnt, w_cnt_next;
`ifdef ALU_MUL_EN
    logic [WIDTH-1:0] r_mcand, w_mcand_next;
    logic [WIDTH-1:0] r_hi, w_hi_next;
    logic [SHW:0]     r_mcnt, w_mcnt_next;
`endif

    logic             w_accept;
    logic [WIDTH-1:0] w_opa;
    logic [SHW-1:0]   w_shamt;
    logic [WIDTH-1:0] w_add_a, w_add_b, w_add_y;
    logic             w_add_cin, w_add_cout, w_add_v;
    logic             w_done;
    logic [WIDTH-1:0] w_res;
    logic             w_c, w_v;
    logic [WIDTH-1:0] w_shifted;
    logic             w_shout;

    // The accumulator register is updated on the completion edge itself, so a
    // request accepted in the following cycle already reads the new value.
    assign w_opa    = use_acc ? r_acc : a;
    assign w_accept = in_valid && (r_state == ST_IDLE);
    assign w_shamt  = b[SHW-1:0];

    assign in_ready  = (r_state == ST_IDLE);
    assign busy      = ~in_ready;
    assign result    = r_result;
    assign flags     = r_flags;
    assign out_valid = r_out_valid;

    // Adder operand steering: ADD/SUB/ADC in IDLE, partial-sum accumulate in MUL.
    always_comb begin
        w_add_a   = w_opa;
        w_add_b   = b;
        w_add_cin = 1'b0;
        if (op == OP_SUB) begin
            w_add_b   = ~b;
            w_add_cin = 1'b1;
        end else if (op == OP_ADC) begin
            w_add_cin = r_flags[FLG_C];
        end
`ifdef ALU_MUL_EN
        if (r_state == ST_MUL) begin
            w_add_a   = r_hi;
            w_add_b   = r_work[0] ? r_mcand : '0;
            w_add_cin = 1'b0;
        end
`endif
    end

    alu_adder_n #(
        .WIDTH (WIDTH)
    ) u_adder (
        .i_a    (w_add_a),
        .i_b    (w_add_b),
        .i_cin  (w_add_cin),
        .o_y    (w_add_y),
        .o_cout (w_add_cout),
        .o_v    (w_add_v)
    );

    // One shift step of the captured operand and the bit that falls off the end.
    always_comb begin
        w_shifted = r_work;
        w_shout   = 1'b0;
        case (r_op)
            OP_SHL: begin
                w_shifted = {r_work[WIDTH-2:0], 1'b0};
                w_shout   = r_work[WIDTH-1];
            end
            OP_SHR: begin
                w_shifted = {1'b0, r_work[WIDTH-1:1]};
                w_shout   = r_work[0];
            end
            default: begin
                w_shifted = {r_work[WIDTH-1], r_work[WIDTH-1:1]};
                w_shout   = r_work[0];
            end
        endcase
    end

    // Next-state and datapath: accept in IDLE, iterate in SHIFT/MUL, then
    // commit result, flags and accumulator together on completion.
    always_comb begin
        w_state_next     = r_state;
        w_result_next    = r_result;
        w_flags_next     = r_flags;
        w_acc_next       = r_acc;
        w_out_valid_next = 1'b0;
        w_op_next        = r_op;
        w_work_next      = r_work;
        w_cnt_next       = r_cnt;
`ifdef ALU_MUL_EN
        w_mcand_next     = r_mcand;
        w_hi_next        = r_hi;
        w_mcnt_next      = r_mcnt;
`endif
        w_done           = 1'b0;
        w_res            = r_result;
        w_c              = 1'b0;
        w_v              = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    case (op)
                        OP_ADD, OP_SUB, OP_ADC: begin
                            w_done = 1'b1;
                            w_res  = w_add_y;
                            w_c    = w_add_cout;
                            w_v    = w_add_v;
                        end
                        OP_AND: begin
                            w_done = 1'b1;
                            w_res  = w_opa & b;
                        end
                        OP_OR: begin
                            w_done = 1'b1;
                            w_res  = w_opa | b;
                        end
                        OP_XOR: begin
                            w_done = 1'b1;
                            w_res  = w_opa ^ b;
                        end
                        OP_SHL, OP_SHR, OP_ASR: begin
                            if (w_shamt == '0) begin
                                w_done = 1'b1;
                                w_res  = w_opa;
                            end else begin
                                w_state_next = ST_SHIFT;
                                w_op_next    = op;
                                w_work_next  = w_opa;
                                w_cnt_next   = w_shamt;
                            end
                        end
`ifdef ALU_MUL_EN
                        OP_MUL: begin
                            w_state_next = ST_MUL;
                            w_mcand_next = w_opa;
                            w_work_next  = b;
                            w_hi_next    = '0;
                            w_mcnt_next  = (SHW+1)'(WIDTH);
                        end
`endif
                        OP_PASS: begin
                            w_done = 1'b1;
                            w_res  = w_opa;
                        end
                        default: begin
                            w_done = 1'b1;
                            w_res  = w_opa;
                        end
                    endcase
                end
            end
            ST_SHIFT: begin
                w_work_next = w_shifted;
                w_cnt_next  = r_cnt - SHW'(1);
                if (r_cnt == SHW'(1)) begin
                    w_state_next = ST_IDLE;
                    w_done       = 1'b1;
                    w_res        = w_shifted;
                    w_c          = w_shout;
                end
            end
`ifdef ALU_MUL_EN
            ST_MUL: begin
                // {hi, lo} shifts right one bit with the new partial sum on top.
                w_hi_next   = {w_add_cout, w_add_y[WIDTH-1:1]};
                w_work_next = {w_add_y[0], r_work[WIDTH-1:1]};
                w_mcnt_next = r_mcnt - (SHW+1)'(1);
                if (r_mcnt == (SHW+1)'(1)) begin
                    w_state_next = ST_IDLE;
                    w_done       = 1'b1;
                    w_res        = w_work_next;
                    w_c          = |w_hi_next;
                    w_v          = |w_hi_next;
                end
            end
`endif
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        if (w_done) begin
            w_result_next    = w_res;
            w_flags_next     = pack_flags(w_res == '0, w_res[WIDTH-1], w_c, w_v);
            w_acc_next       = w_res;
            w_out_valid_next = 1'b1;
        end
    end

    // State and datapath registers; reset abandons any op in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_result    <= '0;
            r_flags     <= '0;
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_op        <= '0;
            r_work      <= '0;
            r_cnt       <= '0;
`ifdef ALU_MUL_EN
            r_mcand     <= '0;
            r_hi        <= '0;
            r_mcnt      <= '0;
`endif
        end else begin
            r_state     <= w_state_next;
            r_result    <= w_result_next;
            r_flags     <= w_flags_next;
            r_acc       <= w_acc_next;
            r_out_valid <= w_out_valid_next;
            r_op        <= w_op_next;
            r_work      <= w_work_next;
            r_cnt       <= w_cnt_next;
`ifdef ALU_MUL_EN
            r_mcand     <= w_mcand_next;
            r_hi        <= w_hi_next;
            r_mcnt      <= w_mcnt_next;
`endif
        end
    end

endmodule

// File: tb/tb_alu_seq_acc.sv
// Self-checking bench for alu_seq_acc at WIDTH=8: directed cases followed by
// random operations checked against an arithmetic reference model.
module tb_alu_seq_acc;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] op = 4'd0;
    logic       use_acc = 1'b0;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic [7:0] result;
    logic [3:0] flags;
    logic       out_valid;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: accumulator and carry flag after the last completion.
    logic [7:0] m_acc = 8'h00;
    logic       m_c = 1'b0;

    logic [3:0] rop;
    logic       rua;
    logic [7:0] ra, rb, eopa, er;
    logic [3:0] ef;
    int         el;

    always #5 clk = ~clk;

    alu_seq_acc #(
        .WIDTH (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .use_acc   (use_acc),
        .a         (a),
        .b         (b),
        .result    (result),
        .flags     (flags),
        .out_valid (out_valid),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Expected outcome from the opcode's arithmetic definition.
    task automatic model(input logic [3:0] mop, input logic [7:0] ma, input logic [7:0] mb,
                         input logic mcin, output logic [7:0] mres, output logic [3:0] mfl,
                         output int mlat);
        logic [8:0]  s;
        logic [15:0] t;
        logic [2:0]  n;
        logic        c, v;
        c    = 1'b0;
        v    = 1'b0;
        mlat = 1;
        n    = mb[2:0];
        mres = ma;
        s    = '0;
        t    = '0;
        case (mop)
            4'd0: begin
                s = {1'b0, ma} + {1'b0, mb};
                mres = s[7:0]; c = s[8];
                v = (ma[7] == mb[7]) && (mres[7] != ma[7]);
            end
            4'd1: begin
                s = {1'b0, ma} + {1'b0, ~mb} + 9'd1;
                mres = s[7:0]; c = s[8];
                v = (ma[7] != mb[7]) && (mres[7] != ma[7]);
            end
            4'd2: mres = ma & mb;
            4'd3: mres = ma | mb;
            4'd4: mres = ma ^ mb;
            4'd6: begin
                s = {1'b0, ma} + {1'b0, mb} + {8'd0, mcin};
                mres = s[7:0]; c = s[8];
                v = (ma[7] == mb[7]) && (mres[7] != ma[7]);
            end
            4'd7: begin
                t = {8'h00, ma} << n;
                mres = t[7:0];
                c = (n != 3'd0) && t[8];
                mlat = int'(n) + 1;
            end
            4'd8: begin
                mres = ma >> n;
                if (n != 3'd0) c = ma[int'(n) - 1];
                mlat = int'(n) + 1;
            end
            4'd9: begin
                mres = $signed(ma) >>> n;
                if (n != 3'd0) c = ma[int'(n) - 1];
                mlat = int'(n) + 1;
            end
`ifdef ALU_MUL_EN
            4'd10: begin
                t = {8'h00, ma} * {8'h00, mb};
                mres = t[7:0];
                c = |t[15:8];
                v = c;
                mlat = 9;
            end
`endif
            default: mres = ma;
        endcase
        mfl = {mres == 8'h00, mres[7], c, v};
    endtask

    // Issue one request, wait for completion, check result/flags/latency/pulse.
    task automatic do_op(input string tag, input logic [3:0] op_i, input logic ua,
                         input logic [7:0] a_i, input logic [7:0] b_i,
                         input logic [7:0] exp_res, input logic [3:0] exp_fl, input int exp_lat);
        int lat;
        int nbusy;
        bit seen;
        @(negedge clk);
        chk($sformatf("%s.ready", tag), 32'(in_ready), 32'd1);
        op = op_i; use_acc = ua; a = a_i; b = b_i; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 8'($urandom); b = 8'($urandom); op = 4'($urandom); use_acc = 1'($urandom);
        lat = 1; nbusy = 0; seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                in_valid = 1'b0;
                break;
            end
            if (!in_ready) begin
                nbusy++;
                in_valid = 1'($urandom);   // must be ignored while busy
                a = 8'($urandom); b = 8'($urandom); op = 4'($urandom);
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            lat++;
        end
        chk($sformatf("%s.done", tag), 32'(seen), 32'd1);
        chk($sformatf("%s.lat", tag), 32'(lat), 32'(exp_lat));
        chk($sformatf("%s.busycyc", tag), 32'(nbusy), 32'(exp_lat - 1));
        chk($sformatf("%s.res", tag), 32'(result), 32'(exp_res));
        chk($sformatf("%s.flags", tag), 32'(flags), 32'(exp_fl));
        $display("[%0t] %s op=%0d use_acc=%0d a=%h b=%h -> result=%h flags=%b lat=%0d",
                 $time, tag, op_i, ua, a_i, b_i, result, flags, lat);
        @(negedge clk);
        chk($sformatf("%s.pulse", tag), 32'(out_valid), 32'd0);
        m_acc = exp_res;
        m_c   = exp_fl[1];
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst.result", 32'(result), 32'h00);
        chk("rst.flags", 32'(flags), 32'h0);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        chk("rst.busy", 32'(busy), 32'd0);
        $display("[%0t] reset released", $time);

        // Directed cases
        do_op("add", 4'd0, 1'b0, 8'h7F, 8'h01, 8'h80, 4'b0101, 1);
        do_op("sub", 4'd1, 1'b0, 8'h05, 8'h05, 8'h00, 4'b1010, 1);
        do_op("adc", 4'd6, 1'b1, 8'($urandom), 8'hFF, 8'h00, 4'b1010, 1);
        do_op("shl", 4'd7, 1'b0, 8'h81, 8'h03, 8'h08, 4'b0000, 4);
        do_op("asr", 4'd9, 1'b0, 8'h80, 8'h01, 8'hC0, 4'b0100, 2);
        do_op("shl0", 4'd7, 1'b0, 8'hA5, 8'h08, 8'hA5, 4'b0100, 1);
`ifdef ALU_MUL_EN
        do_op("mul", 4'd10, 1'b0, 8'h10, 8'h10, 8'h00, 4'b1011, 9);
`else
        do_op("mul", 4'd10, 1'b0, 8'h10, 8'h10, 8'h10, 4'b0000, 1);
`endif
        do_op("pass", 4'd5, 1'b0, 8'h5A, 8'h33, 8'h5A, 4'b0000, 1);

        // Reset in the middle of a shift by 5
        @(negedge clk);
        op = 4'd7; use_acc = 1'b0; a = 8'hFF; b = 8'h05; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rstmid.inflight", 32'(in_ready), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("rstmid.out_valid", 32'(out_valid), 32'd0);
            chk("rstmid.in_ready", 32'(in_ready), 32'd1);
            chk("rstmid.result", 32'(result), 32'h00);
            chk("rstmid.flags", 32'(flags), 32'h0);
            @(negedge clk);
        end
        $display("[%0t] reset during shift checked", $time);
        m_acc = 8'h00;
        m_c   = 1'b0;
        do_op("acc0", 4'd0, 1'b1, 8'hC3, 8'h00, 8'h00, 4'b1000, 1);

        // Back-to-back accumulate: acc+1 every cycle
        op = 4'd0; use_acc = 1'b1; b = 8'h01; a = 8'($urandom); in_valid = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            a = 8'($urandom);
            if (k == 3) in_valid = 1'b0;
            @(negedge clk);
            chk("b2b.out_valid", 32'(out_valid), 32'd1);
            chk("b2b.result", 32'(result), 32'(k));
            chk("b2b.flags", 32'(flags), 32'h0);
            chk("b2b.in_ready", 32'(in_ready), 32'd1);
            $display("[%0t] b2b step=%0d result=%h flags=%b", $time, k, result, flags);
        end
        m_acc = 8'h03;
        m_c   = 1'b0;

        // Random operations against the reference model
        for (int t = 0; t < 40; t++) begin
            rop  = 4'($urandom);
            rua  = 1'($urandom);
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            eopa = rua ? m_acc : ra;
            model(rop, eopa, rb, m_c, er, ef, el);
            do_op($sformatf("rnd%0d", t), rop, rua, ra, rb, er, ef, el);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
